live_fanout_ctrl: RTL

//  Run sequencer for the live fanout stage of the top CDT. Drives test_mode and per-channel

---
 rtl/cdt_pkg.sv | 15 +
 rtl/live_edge_det.sv | 23 ++
 rtl/live_fanout_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cdt_pkg.sv
// Shared types and default sizes for the CDT live fanout sequencer.
package cdt_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitGap,
        StArmed,
        StRun,
        StStopping
    } run_state_e;

    localparam int unsigned N_CH_DEF    = 8;
    localparam int unsigned SPILL_W_DEF = 16;

endpackage

// File: rtl/live_edge_det.sv
// Registers the live level and flags its rising and falling edges.
module live_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic in_live,
    output logic rise,
    output logic fall
);

    logic r_live_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live_q <= 1'b0;
        end else begin
            r_live_q <= in_live;
        end
    end

    assign rise = in_live & ~r_live_q;
    assign fall = r_live_q & ~in_live;

endmodule

// File: rtl/live_fanout_ctrl.sv
// Run sequencer for the live fanout stage: gap-aligned run entry/exit, spill-aligned mask updates.
// Optional auto-stop after cfg_max_spill spills is enabled by defining SPILL_LIMIT_EN.
module live_fanout_ctrl
    import cdt_pkg::*;
#(
    parameter int unsigned N_CH    = N_CH_DEF,
    parameter int unsigned SPILL_W = SPILL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_live,
    input  logic               run_start,
    input  logic               run_stop,
    input  logic [N_CH-1:0]    cfg_ch_mask,
    input  logic               cfg_mask_wr,
    input  logic [SPILL_W-1:0] cfg_max_spill,
    output logic               test_mode,
    output logic [N_CH-1:0]    live_disabled,
    output logic               run_active,
    output logic [SPILL_W-1:0] spill_count,
    output logic               spill_done,
    output logic               limit_hit
);

    run_state_e         r_state, w_state_d;
    logic [N_CH-1:0]    r_shadow, w_shadow_d;
    logic [N_CH-1:0]    r_active, w_active_d;
    logic [SPILL_W-1:0] r_count, w_count_d, w_count_inc;
    logic               r_test_mode, r_run_active, r_spill_done, r_limit_hit;
    logic [N_CH-1:0]    r_live_dis;
    logic               w_done_d, w_limit_d, w_run_d;
    logic               w_rise, w_fall;

`ifdef SPILL_LIMIT_EN
    logic [SPILL_W-1:0] r_max, w_max_d;
`else
    logic               w_unused_max;
    assign w_unused_max = ^cfg_max_spill;
`endif

    live_edge_det u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_live (in_live),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    assign w_count_inc = (r_count == {SPILL_W{1'b1}}) ? r_count : r_count + 1'b1;
    assign w_shadow_d  = cfg_mask_wr ? cfg_ch_mask : r_shadow;

    always_comb begin
        w_state_d  = r_state;
        w_count_d  = r_count;
        w_active_d = r_active;
        w_done_d   = 1'b0;
        w_limit_d  = 1'b0;
`ifdef SPILL_LIMIT_EN
        w_max_d    = r_max;
`endif
        unique case (r_state)
            StIdle: begin
                if (run_start && !run_stop) w_state_d = StWaitGap;
            end
            StWaitGap: begin
                if (run_stop) begin
                    w_state_d = StIdle;
                end else if (!in_live) begin
                    w_state_d  = StArmed;
                    w_count_d  = '0;
                    w_active_d = r_shadow;
`ifdef SPILL_LIMIT_EN
                    w_max_d    = cfg_max_spill;
`endif
                end
            end
            StArmed: begin
                // Armed is only entered with live low, so a high level here is a rise.
                if (run_stop) w_state_d = StIdle;
                else if (w_rise) w_state_d = StRun;
            end
            StRun: begin
                if (w_fall) begin
                    w_count_d  = w_count_inc;
                    w_done_d   = 1'b1;
                    w_active_d = r_shadow;
`ifdef SPILL_LIMIT_EN
                    if (r_max != '0 && w_count_inc == r_max) begin
                        w_state_d = StIdle;
                        w_limit_d = 1'b1;
                    end
`endif
                end
                if (run_stop) w_state_d = in_live ? StStopping : StIdle;
            end
            StStopping: begin
                if (w_fall) begin
                    w_count_d  = w_count_inc;
                    w_done_d   = 1'b1;
                    w_active_d = r_shadow;
                    w_state_d  = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs follow the next state so they change on the transition edge itself.
    assign w_run_d = (w_state_d == StArmed) || (w_state_d == StRun) || (w_state_d == StStopping);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_shadow     <= '1;
            r_active     <= '1;
            r_count      <= '0;
            r_test_mode  <= 1'b1;
            r_live_dis   <= '1;
            r_run_active <= 1'b0;
            r_spill_done <= 1'b0;
            r_limit_hit  <= 1'b0;
`ifdef SPILL_LIMIT_EN
            r_max        <= '0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_shadow     <= w_shadow_d;
            r_active     <= w_active_d;
            r_count      <= w_count_d;
            r_test_mode  <= ~w_run_d;
            r_live_dis   <= w_run_d ? ~w_active_d : '1;
            r_run_active <= w_run_d;
            r_spill_done <= w_done_d;
            r_limit_hit  <= w_limit_d;
`ifdef SPILL_LIMIT_EN
            r_max        <= w_max_d;
`endif
        end
    end

    assign test_mode     = r_test_mode;
    assign live_disabled = r_live_dis;
    assign run_active    = r_run_active;
    assign spill_count   = r_count;
    assign spill_done    = r_spill_done;
    assign limit_hit     = r_limit_hit;

endmodule
